// File: rtl/drum_grid_engine.sv
// drum_grid_engine
//
// Purpose:
//   Holds a ROWS x COLS membrane of signed fixed-point nodes and advances every
//   node by one damped finite-difference wave-equation step per clock while a
//   run is active. Initial conditions are loaded node by node (or cleared) while
//   idle. A start/done handshake runs a programmed number of steps, hold stalls
//   the run, and results saturate to the node word range.
//
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   asynchronous, active-low; clears all state
//   rho         in   signed coupling coefficient (FRAC fractional bits)
//   init_we     in   write init_data into node (init_row, init_col), idle only
//   init_row    in   load row address
//   init_col    in   load column address
//   init_data   in   signed initial displacement
//   clear       in   zero the whole grid, idle only; wins over init_we
//   start       in   begin a run of num_steps steps, idle only
//   num_steps   in   step count, latched when start is accepted
//   hold        in   stall the run (no commit, counter frozen)
//   busy        out  high while running
//   done        out  one-cycle pulse when a run completes
//   step_valid  out  high the cycle after each committed step
//   steps_done  out  steps committed in the current/last run
//   out_sample  out  current displacement of node (TAP_ROW, TAP_COL)

module drum_grid_engine #(
    parameter int ROWS      = 8,
    parameter int COLS      = 8,
    parameter int WIDTH     = 18,
    parameter int FRAC      = 17,
    parameter int ETA_SHIFT = 10,
    parameter int ITER_W    = 16,
    parameter int TAP_ROW   = ROWS / 2,
    parameter int TAP_COL   = COLS / 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic signed [WIDTH-1:0]    rho,
    input  logic                       init_we,
    input  logic [$clog2(ROWS)-1:0]    init_row,
    input  logic [$clog2(COLS)-1:0]    init_col,
    input  logic signed [WIDTH-1:0]    init_data,
    input  logic                       clear,
    input  logic                       start,
    input  logic [ITER_W-1:0]          num_steps,
    input  logic                       hold,
    output logic                       busy,
    output logic                       done,
    output logic                       step_valid,
    output logic [ITER_W-1:0]          steps_done,
    output logic signed [WIDTH-1:0]    out_sample
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    // Laplacian width: four neighbours plus 4*u.
    localparam int LW = WIDTH + 3;
    // Wide working width so rho*lap and the damped sum never wrap before saturation.
    localparam int XW = 2 * WIDTH + 8;

    localparam logic [RW:0] ROWS_L = (RW + 1)'(ROWS);
    localparam logic [CW:0] COLS_L = (CW + 1)'(COLS);

    localparam logic signed [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic signed [WIDTH-1:0] u_cur    [ROWS][COLS];
    logic signed [WIDTH-1:0] u_prev   [ROWS][COLS];
    logic signed [WIDTH-1:0] next_val [ROWS][COLS];

    logic [ITER_W-1:0] num_q;
    logic              start_ok;
    logic              commit;
    logic              last_step;
    logic              addr_ok;

    assign start_ok  = (state == IDLE) && start;
    assign commit    = (state == RUN) && !hold;
    assign last_step = (steps_done + ITER_W'(1)) == num_q;
    assign addr_ok   = ({1'b0, init_row} < ROWS_L) && ({1'b0, init_col} < COLS_L);

    // Per-node update datapath. Missing neighbours at the border are tied to
    // zero, which models a membrane clamped along its edges.
    for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
        for (genvar gc = 0; gc < COLS; gc++) begin : g_col
            logic signed [WIDTH-1:0] nb_l, nb_r, nb_u, nb_d;
            logic signed [LW-1:0]    lap;
            logic signed [XW-1:0]    prod_full;
            logic signed [XW-1:0]    prod;
            logic signed [XW-1:0]    dprev;
            logic signed [XW-1:0]    raw;
            logic signed [XW-1:0]    damped;
            logic signed [WIDTH-1:0] sat_val;

            if (gc > 0) begin : g_l
                assign nb_l = u_cur[gr][gc-1];
            end else begin : g_l0
                assign nb_l = '0;
            end
            if (gc < COLS - 1) begin : g_r
                assign nb_r = u_cur[gr][gc+1];
            end else begin : g_r0
                assign nb_r = '0;
            end
            if (gr > 0) begin : g_u
                assign nb_u = u_cur[gr-1][gc];
            end else begin : g_u0
                assign nb_u = '0;
            end
            if (gr < ROWS - 1) begin : g_d
                assign nb_d = u_cur[gr+1][gc];
            end else begin : g_d0
                assign nb_d = '0;
            end

            assign lap = LW'(nb_l) + LW'(nb_r) + LW'(nb_u) + LW'(nb_d)
                       - (LW'(u_cur[gr][gc]) <<< 2);

            // Arithmetic shift of the signed product gives floor rounding.
            assign prod_full = XW'(rho) * XW'(lap);
            assign prod      = prod_full >>> FRAC;

            assign dprev  = XW'(u_prev[gr][gc]) - (XW'(u_prev[gr][gc]) >>> ETA_SHIFT);
            assign raw    = (XW'(u_cur[gr][gc]) <<< 1) - dprev + prod;
            assign damped = raw - (raw >>> ETA_SHIFT);

            // Clamp to the node word range instead of letting the value wrap.
            always_comb begin
                if (damped > XW'(SAT_MAX)) begin
                    sat_val = SAT_MAX;
                end else if (damped < XW'(SAT_MIN)) begin
                    sat_val = SAT_MIN;
                end else begin
                    sat_val = damped[WIDTH-1:0];
                end
            end

            assign next_val[gr][gc] = sat_val;
        end
    end

    // Grid storage. Loading writes both time levels so a node starts at rest.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    u_cur[r][c]  <= '0;
                    u_prev[r][c] <= '0;
                end
            end
        end else if (state == IDLE) begin
            if (clear) begin
                for (int r = 0; r < ROWS; r++) begin
                    for (int c = 0; c < COLS; c++) begin
                        u_cur[r][c]  <= '0;
                        u_prev[r][c] <= '0;
                    end
                end
            end else if (init_we && addr_ok) begin
                u_cur[init_row][init_col]  <= init_data;
                u_prev[init_row][init_col] <= init_data;
            end
        end else if (commit) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    u_prev[r][c] <= u_cur[r][c];
                    u_cur[r][c]  <= next_val[r][c];
                end
            end
        end
    end

    // Run bookkeeping: latched step target, committed-step counter and the
    // step_valid flag that follows each commit by one cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            num_q      <= '0;
            steps_done <= '0;
            step_valid <= 1'b0;
        end else begin
            step_valid <= commit;
            if (start_ok) begin
                num_q      <= num_steps;
                steps_done <= '0;
            end else if (commit) begin
                steps_done <= steps_done + ITER_W'(1);
            end
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A zero-length run goes straight to DONE so the caller
    // still sees a completion pulse.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (num_steps == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (commit && last_step) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign out_sample = u_cur[TAP_ROW][TAP_COL];

endmodule

// File: tb/tb_drum_grid_engine.sv
// tb_drum_grid_engine
//
// Purpose:
//   Directed self-checking bench for drum_grid_engine on a 4x4 grid with the
//   output tap moved to node (1,1), so single-step responses of a loaded node
//   and of its neighbours can be observed by loading at different positions.
//
// Ports: none (top-level bench).

module tb_drum_grid_engine;

    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int WIDTH  = 18;
    localparam int ITER_W = 16;

    logic                    clock = 1'b0;
    logic                    reset = 1'b0;
    logic signed [WIDTH-1:0] rho = '0;
    logic                    init_we = 1'b0;
    logic [1:0]              init_row = '0;
    logic [1:0]              init_col = '0;
    logic signed [WIDTH-1:0] init_data = '0;
    logic                    clear = 1'b0;
    logic                    start = 1'b0;
    logic [ITER_W-1:0]       num_steps = '0;
    logic                    hold = 1'b0;
    logic                    busy;
    logic                    done;
    logic                    step_valid;
    logic [ITER_W-1:0]       steps_done;
    logic signed [WIDTH-1:0] out_sample;

    int checks = 0;
    int failures = 0;

    drum_grid_engine #(
        .ROWS(ROWS), .COLS(COLS), .WIDTH(WIDTH), .FRAC(17), .ETA_SHIFT(10),
        .ITER_W(ITER_W), .TAP_ROW(1), .TAP_COL(1)
    ) dut (
        .clock(clock), .reset(reset), .rho(rho),
        .init_we(init_we), .init_row(init_row), .init_col(init_col),
        .init_data(init_data), .clear(clear), .start(start),
        .num_steps(num_steps), .hold(hold), .busy(busy), .done(done),
        .step_valid(step_valid), .steps_done(steps_done),
        .out_sample(out_sample)
    );

    always #5 clock = ~clock;

    // Stimulus helpers; each is entered and left on a falling edge.
    task automatic load_node(input int r, input int c, input int v);
        init_we   = 1'b1;
        init_row  = r[1:0];
        init_col  = c[1:0];
        init_data = v[WIDTH-1:0];
        @(negedge clock);
        init_we = 1'b0;
    endtask

    task automatic clear_grid();
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
    endtask

    // Start a run and wait (bounded) for its done pulse, then one more cycle.
    task automatic do_run(input int n);
        bit seen;
        seen      = 1'b0;
        num_steps = n[ITER_W-1:0];
        start     = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clock);
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("[TB] FAIL run_timeout: done=%0b required 1 within 100 cycles", done);
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({busy, done, step_valid} !== 3'b000 || steps_done !== '0 || out_sample !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: busy=%0b done=%0b sv=%0b steps=%0d out=%0d required all 0",
                     busy, done, step_valid, steps_done, out_sample);
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || out_sample !== '0) begin
            failures++;
            $display("[TB] FAIL reset_idle: busy=%0b out=%0d required 0 0", busy, out_sample);
        end
    endtask

    task automatic test_single_step();
        int pr [5] = '{0, 1, 1, 2, 0};
        int pc [5] = '{1, 0, 2, 1, 0};
        int ex [5] = '{62, 62, 62, 62, 0};
        clear_grid();
        load_node(1, 1, 1000);
        rho       = 18'sd8192;
        num_steps = 16'd1;
        start     = 1'b1;
        @(negedge clock);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || step_valid !== 1'b0 || out_sample !== 18'sd1000) begin
            failures++;
            $display("[TB] FAIL step_start: busy=%0b sv=%0b out=%0d required 1 0 1000",
                     busy, step_valid, out_sample);
        end
        @(negedge clock);
        checks++;
        if (step_valid !== 1'b1 || done !== 1'b1 || busy !== 1'b0 || steps_done !== 16'd1) begin
            failures++;
            $display("[TB] FAIL step_commit: sv=%0b done=%0b busy=%0b steps=%0d required 1 1 0 1",
                     step_valid, done, busy, steps_done);
        end
        checks++;
        if (out_sample !== 18'sd750) begin
            failures++;
            $display("[TB] FAIL step_center: out=%0d required 750", out_sample);
        end
        @(negedge clock);
        checks++;
        if (done !== 1'b0 || step_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL step_pulses: done=%0b sv=%0b required 0 0", done, step_valid);
        end
        // Loading next to / diagonal to the tap shows the neighbour response at (1,1).
        for (int k = 0; k < 5; k++) begin
            clear_grid();
            load_node(pr[k], pc[k], 1000);
            do_run(1);
            checks++;
            if (out_sample !== ex[k][WIDTH-1:0]) begin
                failures++;
                $display("[TB] FAIL neighbour_%0d_%0d: out=%0d required %0d",
                         pr[k], pc[k], out_sample, ex[k]);
            end
        end
    endtask

    task automatic test_saturation();
        clear_grid();
        load_node(1, 1, 100000);
        rho = -18'sd131072;
        do_run(1);
        checks++;
        if (out_sample !== 18'sd131071 || steps_done !== 16'd1) begin
            failures++;
            $display("[TB] FAIL saturation: out=%0d steps=%0d required 131071 1",
                     out_sample, steps_done);
        end
    endtask

    task automatic test_hold();
        int nb, nv, nd, hold_left;
        bit held;
        nb = 0; nv = 0; nd = 0; hold_left = 0; held = 1'b0;
        clear_grid();
        rho       = 18'sd8192;
        num_steps = 16'd5;
        start     = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clock);
            start = 1'b0;
            if (cyc == 0) begin
                checks++;
                if (steps_done !== '0) begin
                    failures++;
                    $display("[TB] FAIL hold_count_reset: steps=%0d required 0", steps_done);
                end
            end
            nb += int'(busy);
            nv += int'(step_valid);
            nd += int'(done);
            if (hold_left > 0) begin
                if (step_valid !== 1'b0 || steps_done !== 16'd2) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL hold_frozen: sv=%0b steps=%0d required 0 2",
                             step_valid, steps_done);
                end
                hold_left--;
                if (hold_left == 0) hold = 1'b0;
            end
            if (step_valid && nv == 2 && !held) begin
                hold      = 1'b1;
                hold_left = 3;
                held      = 1'b1;
            end
        end
        checks++;
        if (nb != 8 || nv != 5 || nd != 1 || steps_done !== 16'd5) begin
            failures++;
            $display("[TB] FAIL hold_run: busy_cycles=%0d valids=%0d dones=%0d steps=%0d required 8 5 1 5",
                     nb, nv, nd, steps_done);
        end
    endtask

    task automatic test_ignored_in_run();
        clear_grid();
        load_node(1, 1, 1000);
        rho       = 18'sd8192;
        num_steps = 16'd1;
        hold      = 1'b1;
        start     = 1'b1;
        @(negedge clock);
        clear     = 1'b1;
        init_we   = 1'b1;
        init_row  = 2'd1;
        init_col  = 2'd1;
        init_data = 18'sd5;
        num_steps = 16'd4;
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (out_sample !== 18'sd1000 || busy !== 1'b1 || steps_done !== '0) begin
            failures++;
            $display("[TB] FAIL run_ignore_ctrl: out=%0d busy=%0b steps=%0d required 1000 1 0",
                     out_sample, busy, steps_done);
        end
        clear   = 1'b0;
        init_we = 1'b0;
        start   = 1'b0;
        hold    = 1'b0;
        @(negedge clock);
        checks++;
        if (out_sample !== 18'sd750 || done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL run_after_hold: out=%0d done=%0b required 750 1", out_sample, done);
        end
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || steps_done !== 16'd1) begin
            failures++;
            $display("[TB] FAIL no_second_run: busy=%0b steps=%0d required 0 1", busy, steps_done);
        end
        clear     = 1'b1;
        init_we   = 1'b1;
        init_data = 18'sd777;
        @(negedge clock);
        clear   = 1'b0;
        init_we = 1'b0;
        checks++;
        if (out_sample !== '0) begin
            failures++;
            $display("[TB] FAIL clear_wins: out=%0d required 0", out_sample);
        end
    endtask

    task automatic test_zero_steps();
        int nb;
        nb = 0;
        clear_grid();
        load_node(1, 1, 1234);
        num_steps = 16'd0;
        start     = 1'b1;
        @(negedge clock);
        nb += int'(busy);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL zero_done: done=%0b busy=%0b required 1 0", done, busy);
        end
        // Start during the done cycle must be ignored.
        num_steps = 16'd3;
        start     = 1'b1;
        @(negedge clock);
        start = 1'b0;
        nb += int'(busy);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL zero_single_pulse: done=%0b required 0", done);
        end
        @(negedge clock);
        nb += int'(busy);
        checks++;
        if (nb != 0 || out_sample !== 18'sd1234) begin
            failures++;
            $display("[TB] FAIL zero_no_run: busy_cycles=%0d out=%0d required 0 1234", nb, out_sample);
        end
    endtask

    task automatic test_reset_midrun();
        clear_grid();
        load_node(1, 1, 1000);
        rho       = 18'sd8192;
        num_steps = 16'd10;
        start     = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (busy !== 1'b1 || steps_done !== 16'd2) begin
            failures++;
            $display("[TB] FAIL midrun_busy: busy=%0b steps=%0d required 1 2", busy, steps_done);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({busy, done, step_valid} !== 3'b000 || steps_done !== '0 || out_sample !== '0) begin
            failures++;
            $display("[TB] FAIL midrun_reset: busy=%0b done=%0b sv=%0b steps=%0d out=%0d required all 0",
                     busy, done, step_valid, steps_done, out_sample);
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out_sample !== '0) begin
            failures++;
            $display("[TB] FAIL midrun_after: busy=%0b done=%0b out=%0d required 0 0 0",
                     busy, done, out_sample);
        end
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_saturation();
        test_hold();
        test_ignored_in_run();
        test_zero_steps();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
